// File: rtl/sram_controller.sv
// MEM-stage data-memory responder: each 32-bit request is carried out as two
// 16-bit SRAM phases (low half, then high half) followed by a one-cycle DONE.
module sram_controller #(
  parameter int ADDR_BASE    = 1024,
  parameter int PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request (rd_en | wr_en) is accepted on the clock edge where it
  // is seen in IDLE; ready=1 means the stage may advance this cycle (idle with
  // no request, or the access completes now). Requests in DONE wait for IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_is_wr;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_read_data;
  logic [17:0] r_sram_addr;
  logic [15:0] r_sram_dq_out;
  logic        r_sram_dq_oe;
  logic        r_sram_we_n;

  logic        w_req;
  logic        w_last;
  logic [3:0]  w_cnt_next;
  logic [16:0] w_word;

  assign w_req      = wr_en | rd_en;
  assign w_last     = (r_cnt == LAST);
  assign w_cnt_next = r_cnt + 4'd1;
  // Out-of-range addresses simply wrap within the 2^17-word SRAM.
  assign w_word     = 17'((address - 32'(ADDR_BASE)) >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_is_wr       <= 1'b0;
      r_word        <= 17'd0;
      r_wdata       <= 32'd0;
      r_read_data   <= 32'd0;
      r_sram_addr   <= 18'd0;
      r_sram_dq_out <= 16'd0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_we_n   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_sram_we_n  <= 1'b1;
          r_sram_dq_oe <= 1'b0;
          if (w_req) begin
            r_state       <= LO;
            r_cnt         <= 4'd0;
            r_is_wr       <= wr_en;
            r_word        <= w_word;
            r_wdata       <= write_data;
            r_sram_addr   <= {w_word, 1'b0};
            r_sram_dq_out <= write_data[15:0];
            r_sram_dq_oe  <= wr_en;
            r_sram_we_n   <= ~wr_en;
          end
        end
        LO: begin
          if (w_last) begin
            r_state       <= HI;
            r_cnt         <= 4'd0;
            r_sram_addr   <= {r_word, 1'b1};
            r_sram_dq_out <= r_wdata[31:16];
            r_sram_we_n   <= ~r_is_wr;
            if (!r_is_wr) r_read_data[15:0] <= sram_dq_in;
          end else begin
            // Strobe rises on the final cycle so address/data are held past it.
            r_cnt       <= w_cnt_next;
            r_sram_we_n <= ~(r_is_wr && (w_cnt_next != LAST));
          end
        end
        HI: begin
          if (w_last) begin
            r_state      <= DONE;
            r_cnt        <= 4'd0;
            r_sram_we_n  <= 1'b1;
            r_sram_dq_oe <= 1'b0;
            if (!r_is_wr) r_read_data[31:16] <= sram_dq_in;
          end else begin
            r_cnt       <= w_cnt_next;
            r_sram_we_n <= ~(r_is_wr && (w_cnt_next != LAST));
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready       = (r_state == DONE) | ((r_state == IDLE) & ~w_req);
  assign read_data   = r_read_data;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_sram_dq_out;
  assign sram_dq_oe  = r_sram_dq_oe;
  assign sram_we_n   = r_sram_we_n;
  assign o_dbg_state = r_state;

endmodule
